// File: rtl/sound_fx_gen.sv
// Event-driven square-wave sound effect generator for the game buzzer.
// Arbitrates hit/wall/goal/win requests by priority and plays short note sequences.
module sound_fx_gen #(
  parameter logic [15:0] HIT_HALF    = 16'd28409,
  parameter logic [15:0] WALL_HALF   = 16'd56818,
  parameter logic [15:0] GOAL_HALF_A = 16'd37936,
  parameter logic [15:0] GOAL_HALF_B = 16'd18968,
  parameter logic [15:0] WIN_HALF0   = 16'd47778,
  parameter logic [15:0] WIN_HALF1   = 16'd37921,
  parameter logic [15:0] WIN_HALF2   = 16'd31888,
  parameter logic [15:0] WIN_HALF3   = 16'd23889,
  parameter logic [23:0] NOTE_LEN    = 24'd2500000,
  parameter logic [23:0] GAP_LEN     = 24'd500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit,
  input  logic       wall,
  input  logic       goal,
  input  logic       win,
  input  logic       mute,
  output logic       spk,
  output logic       busy,
  output logic [2:0] sound_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] half_cnt_q, half_cnt_d;
  logic [23:0] dur_cnt_q, dur_cnt_d;
  logic [1:0]  note_idx_q, note_idx_d;
  logic        spk_q, spk_d;
  logic        busy_q, busy_d;
  logic [2:0]  sound_id_q, sound_id_d;
  logic        win_prev_q, win_prev_d;

  logic        win_rise;
  logic [2:0]  req_id;
  logic        accept;
  logic [15:0] half_sel;
  logic        last_note;

  assign win_rise = win & ~win_prev_q;

  always_comb begin
    req_id = 3'd0;
    if (win_rise)  req_id = 3'd4;
    else if (goal) req_id = 3'd3;
    else if (hit)  req_id = 3'd2;
    else if (wall) req_id = 3'd1;
  end

  // Strictly higher priority pre-empts; equal or lower requests are dropped.
  assign accept = (req_id != 3'd0) && (req_id > sound_id_q);

  always_comb begin
    half_sel = HIT_HALF;
    case (sound_id_q)
      3'd1: half_sel = WALL_HALF;
      3'd2: half_sel = HIT_HALF;
      3'd3: half_sel = (note_idx_q == 2'd0) ? GOAL_HALF_A : GOAL_HALF_B;
      3'd4: begin
        case (note_idx_q)
          2'd0: half_sel = WIN_HALF0;
          2'd1: half_sel = WIN_HALF1;
          2'd2: half_sel = WIN_HALF2;
          2'd3: half_sel = WIN_HALF3;
        endcase
      end
      default: half_sel = HIT_HALF;
    endcase
  end

  always_comb begin
    last_note = 1'b1;
    case (sound_id_q)
      3'd3:    last_note = (note_idx_q == 2'd1);
      3'd4:    last_note = (note_idx_q == 2'd3);
      default: last_note = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    note_idx_d = note_idx_q;
    spk_d      = spk_q;
    busy_d     = busy_q;
    sound_id_d = sound_id_q;
    win_prev_d = win;

    case (state_q)
      TONE: begin
        dur_cnt_d = dur_cnt_q + 24'd1;
        if (half_cnt_q == half_sel - 16'd1) begin
          half_cnt_d = 16'd0;
          spk_d      = ~spk_q;
        end else begin
          half_cnt_d = half_cnt_q + 16'd1;
        end
        // Note end forces the line low regardless of the toggle phase.
        if (dur_cnt_q == NOTE_LEN - 24'd1) begin
          spk_d      = 1'b0;
          half_cnt_d = 16'd0;
          dur_cnt_d  = 24'd0;
          if (last_note) begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            sound_id_d = 3'd0;
            note_idx_d = 2'd0;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        spk_d     = 1'b0;
        dur_cnt_d = dur_cnt_q + 24'd1;
        if (dur_cnt_q == GAP_LEN - 24'd1) begin
          state_d    = TONE;
          note_idx_d = note_idx_q + 2'd1;
          dur_cnt_d  = 24'd0;
          half_cnt_d = 16'd0;
        end
      end
      default: begin
        state_d    = IDLE;
        spk_d      = 1'b0;
        busy_d     = 1'b0;
        sound_id_d = 3'd0;
        half_cnt_d = 16'd0;
        dur_cnt_d  = 24'd0;
        note_idx_d = 2'd0;
      end
    endcase

    // An accepted request wins over any end-of-note or gap transition.
    if (accept) begin
      state_d    = TONE;
      note_idx_d = 2'd0;
      half_cnt_d = 16'd0;
      dur_cnt_d  = 24'd0;
      spk_d      = 1'b0;
      sound_id_d = req_id;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      half_cnt_q <= 16'd0;
      dur_cnt_q  <= 24'd0;
      note_idx_q <= 2'd0;
      spk_q      <= 1'b0;
      busy_q     <= 1'b0;
      sound_id_q <= 3'd0;
      win_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      note_idx_q <= note_idx_d;
      spk_q      <= spk_d;
      busy_q     <= busy_d;
      sound_id_q <= sound_id_d;
      win_prev_q <= win_prev_d;
    end
  end

  assign spk      = spk_q & ~mute;
  assign busy     = busy_q;
  assign sound_id = sound_id_q;

endmodule

// File: tb/tb_sound_fx_gen.sv
// Directed bench for sound_fx_gen with short notes; expected per-cycle outputs
// are queued with the stimulus and compared as the cycles are reached.
module tb_sound_fx_gen;

  localparam int NL = 40;
  localparam int GL = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hit = 1'b0, wall = 1'b0, goal = 1'b0, win = 1'b0, mute = 1'b0;
  logic       spk, busy;
  logic [2:0] sound_id;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    string      tag;
    int         cyc;
    logic       spk;
    logic       busy;
    logic [2:0] id;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sound_fx_gen #(
    .HIT_HALF(16'd5), .WALL_HALF(16'd8), .GOAL_HALF_A(16'd4), .GOAL_HALF_B(16'd3),
    .WIN_HALF0(16'd6), .WIN_HALF1(16'd5), .WIN_HALF2(16'd4), .WIN_HALF3(16'd3),
    .NOTE_LEN(24'd40), .GAP_LEN(24'd10)
  ) dut (
    .clk(clk), .rst(rst), .hit(hit), .wall(wall), .goal(goal), .win(win),
    .mute(mute), .spk(spk), .busy(busy), .sound_id(sound_id)
  );

  task automatic chk(string tag, logic [2:0] obs, logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(string tag, int c, logic s, logic b, logic [2:0] id);
    exp_t e;
    e.tag = tag; e.cyc = c; e.spk = s; e.busy = b; e.id = id;
    sb.push_back(e);
  endtask

  function automatic int half_of(int id, int k);
    case (id)
      1: return 8;
      2: return 5;
      3: return (k == 0) ? 4 : 3;
      4: begin
        case (k)
          0: return 6;
          1: return 5;
          2: return 4;
          default: return 3;
        endcase
      end
      default: return 1;
    endcase
  endfunction

  function automatic int notes_of(int id);
    return (id == 4) ? 4 : (id == 3) ? 2 : 1;
  endfunction

  // Square wave starting low at 'start', toggling every 'half' cycles.
  task automatic push_note(string tag, int start, int half, int id, int from, int to, bit muted);
    for (int c = from; c <= to; c++)
      push(tag, c, muted ? 1'b0 : ((((c - start) / half) % 2) == 1), 1'b1, 3'(id));
  endtask

  task automatic push_gap(string tag, int from, int to, int id);
    for (int c = from; c <= to; c++) push(tag, c, 1'b0, 1'b1, 3'(id));
  endtask

  task automatic push_idle(string tag, int from, int to);
    for (int c = from; c <= to; c++) push(tag, c, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic push_sound(string tag, int t0, int id);
    int s;
    for (int k = 0; k < notes_of(id); k++) begin
      s = t0 + k * (NL + GL);
      push_note(tag, s, half_of(id, k), id, s, s + NL - 1, 1'b0);
      if (k < notes_of(id) - 1) push_gap(tag, s + NL, s + NL + GL - 1, id);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    hit = 1'b0; wall = 1'b0; goal = 1'b0;
    cyc++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk({e.tag, "/spk"}, {2'b00, spk}, {2'b00, e.spk});
      chk({e.tag, "/busy"}, {2'b00, busy}, {2'b00, e.busy});
      chk({e.tag, "/id"}, sound_id, e.id);
    end
  endtask

  task automatic run_to(int t);
    while (cyc < t) step();
  endtask

  task automatic start_scn();
    repeat (3) step();
    cyc = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset/spk", {2'b00, spk}, 3'd0);
    chk("reset/busy", {2'b00, busy}, 3'd0);
    chk("reset/id", sound_id, 3'd0);
    rst = 1'b0;

    // Single hit note.
    start_scn();
    push_sound("hit", 1, 2);
    push_idle("hit_end", 41, 42);
    hit = 1'b1;
    run_to(42);

    // Two-note goal with gap.
    start_scn();
    push_sound("goal", 1, 3);
    push_idle("goal_end", 91, 92);
    goal = 1'b1;
    run_to(92);

    // Hit pre-empts wall; later wall and repeated hit are dropped.
    start_scn();
    push_note("wall", 1, 8, 1, 1, 15, 1'b0);
    push_note("preempt", 16, 5, 2, 16, 55, 1'b0);
    push_idle("preempt_end", 56, 57);
    wall = 1'b1;
    run_to(15);
    hit = 1'b1;
    run_to(30);
    wall = 1'b1;
    run_to(35);
    hit = 1'b1;
    run_to(57);

    // Goal arriving on the hit note's final cycle takes over.
    start_scn();
    push_sound("end_hit", 1, 2);
    push_sound("end_goal", 41, 3);
    push_idle("end_goal_idle", 131, 132);
    hit = 1'b1;
    run_to(40);
    goal = 1'b1;
    run_to(132);

    // Simultaneous pulses: only goal plays.
    start_scn();
    push_sound("simul", 1, 3);
    push_idle("simul_end", 91, 92);
    hit = 1'b1; wall = 1'b1; goal = 1'b1;
    run_to(92);

    // Win held high: one jingle only.
    start_scn();
    push_sound("win", 1, 4);
    push_idle("win_hold", 191, 195);
    push_idle("win_hold", 300, 300);
    push_idle("win_hold", 499, 499);
    push_idle("win_low", 501, 502);
    win = 1'b1;
    run_to(499);
    win = 1'b0;
    run_to(502);

    // Mute over the first half of goal note A; toggling phase must persist.
    start_scn();
    push_note("mute", 1, 4, 3, 1, 20, 1'b1);
    push_note("unmute", 1, 4, 3, 21, 40, 1'b0);
    push_gap("unmute_gap", 41, 50, 3);
    push_note("unmute_b", 51, 3, 3, 51, 90, 1'b0);
    push_idle("unmute_end", 91, 91);
    mute = 1'b1;
    goal = 1'b1;
    run_to(20);
    mute = 1'b0;
    run_to(91);

    // Asynchronous reset in the middle of the win jingle.
    start_scn();
    push_note("rst_win", 1, 6, 4, 1, 40, 1'b0);
    push_gap("rst_win_gap", 41, 50, 4);
    push_note("rst_win_b", 51, 5, 4, 51, 57, 1'b0);
    win = 1'b1;
    run_to(57);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid/spk", {2'b00, spk}, 3'd0);
    chk("rst_mid/busy", {2'b00, busy}, 3'd0);
    chk("rst_mid/id", sound_id, 3'd0);
    win = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_scn();
    push_idle("post_rst", 1, 5);
    run_to(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
